// File: rtl/store_drain_ctrl_pkg.sv
// Shared types for the committed-store buffer and its forwarding CAM.
// Optional forwarding is built only when STORE_FWD_EN is defined.
package store_drain_ctrl_pkg;

  typedef logic [63:0] ADDR;
  typedef logic [63:0] DATA;

  localparam int SB_DEPTH_DFLT     = 8;
  localparam int STARVE_LIMIT_DFLT = 16;

  typedef logic [$clog2(SB_DEPTH_DFLT)-1:0] SB_PTR;

  typedef struct packed {
    ADDR addr;
    DATA data;
  } SB_ENTRY_t;

  typedef enum logic [1:0] {SB_IDLE, SB_ISSUE, SB_URGENT} SB_STATE_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/store_drain_ctrl_fwd_cam.sv
// Youngest-match store-to-load forwarding CAM for one load probe port.
// Compiled only when STORE_FWD_EN is defined.
`ifdef STORE_FWD_EN
module sb_fwd_cam
  import store_drain_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DFLT
) (
  input  SB_ENTRY_t [SB_DEPTH-1:0]       i_mem,
  input  logic [$clog2(SB_DEPTH)-1:0]    i_head,
  input  logic [$clog2(SB_DEPTH):0]      i_count,
  input  logic [63:0]                    i_ld_addr,
  output logic                           o_hit,
  output logic [63:0]                    o_data
);
  localparam int PW = $clog2(SB_DEPTH);

  ADDR  w_key;
  logic w_unused_lo;

  // Stored addresses already have [2:0] cleared, so match on the full word.
  assign w_key       = {i_ld_addr[63:3], 3'b000};
  assign w_unused_lo = ^i_ld_addr[2:0];

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (k < int'(i_count) && i_mem[i_head + PW'(k)].addr == w_key) begin
        o_hit  = 1'b1;
        o_data = i_mem[i_head + PW'(k)].data;
      end
    end
  end

endmodule
`endif

// File: rtl/store_drain_ctrl.sv
// Committed-store buffer: in-order drain to the cache store port with retry and starvation escalation.
// Define STORE_FWD_EN to add store-to-load forwarding on the two probe ports.
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int SB_DEPTH     = SB_DEPTH_DFLT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rt_st_valid,
  input  logic [1:0][63:0] rt_st_addr,
  input  logic [1:0][63:0] rt_st_data,
  output logic             sb_stall,
  output logic             st_request_valid,
  output logic [63:0]      st_requested_addr,
  output logic [63:0]      st_request_data,
  input  logic             st_request_sent,
  output logic             st_urgent,
  input  logic             drain_req,
  output logic             sb_drained,
  input  logic [1:0][63:0] ld_addr,
  output logic [1:0]       ld_fwd_valid,
  output logic [1:0][63:0] ld_fwd_data
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  SB_ENTRY_t [SB_DEPTH-1:0] r_mem;
  logic [PW-1:0]            r_head, r_tail, w_tail1;
  logic [CW-1:0]            r_count, w_enq_n;
  SB_STATE_t                r_state, w_state_nxt;
  logic [SW-1:0]            r_starve, w_starve_nxt;
  logic                     w_enq_ok, w_acc, w_refuse, w_unused_lo;

  // Stall looks only at the registered count; a same-cycle pop gives no credit.
  assign sb_stall         = (SB_DEPTH - int'(r_count)) < 2;
  assign st_request_valid = (r_count != '0);
  assign w_acc            = st_request_valid && st_request_sent;
  assign w_refuse         = st_request_valid && !st_request_sent;
  assign w_enq_ok         = !sb_stall;
  assign w_enq_n          = w_enq_ok ? CW'(popcnt2(rt_st_valid)) : '0;
  assign w_tail1          = rt_st_valid[0] ? r_tail + PW'(1) : r_tail;
  assign w_unused_lo      = ^{rt_st_addr[0][2:0], rt_st_addr[1][2:0]};

  assign st_requested_addr = st_request_valid ? r_mem[r_head].addr : '0;
  assign st_request_data   = st_request_valid ? r_mem[r_head].data : '0;
  assign st_urgent         = (r_state == SB_URGENT);
  assign sb_drained        = drain_req && (r_count == '0);

  // Entry storage needs no reset: nothing is visible until count covers it.
  always_ff @(posedge clk) begin
    if (w_enq_ok && rt_st_valid[0])
      r_mem[r_tail] <= '{addr: {rt_st_addr[0][63:3], 3'b000}, data: rt_st_data[0]};
    if (w_enq_ok && rt_st_valid[1])
      r_mem[w_tail1] <= '{addr: {rt_st_addr[1][63:3], 3'b000}, data: rt_st_data[1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_state  <= SB_IDLE;
      r_starve <= '0;
    end else begin
      r_head   <= r_head + PW'(w_acc);
      r_tail   <= r_tail + PW'(w_enq_n);
      r_count  <= r_count + w_enq_n - CW'(w_acc);
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      SB_IDLE: if (w_enq_n != '0) w_state_nxt = SB_ISSUE;
      SB_ISSUE, SB_URGENT: begin
        if (w_acc) begin
          w_starve_nxt = '0;
          w_state_nxt  = (r_count == CW'(1) && w_enq_n == '0) ? SB_IDLE : SB_ISSUE;
        end else if (w_refuse) begin
          if (r_starve != '1) w_starve_nxt = r_starve + SW'(1);
          if (r_state == SB_ISSUE && r_starve == SW'(STARVE_LIMIT - 1))
            w_state_nxt = SB_URGENT;
        end
      end
      default: w_state_nxt = SB_IDLE;
    endcase
  end

`ifdef STORE_FWD_EN
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    sb_fwd_cam #(.SB_DEPTH(SB_DEPTH)) u_cam (
      .i_mem     (r_mem),
      .i_head    (r_head),
      .i_count   (r_count),
      .i_ld_addr (ld_addr[p]),
      .o_hit     (ld_fwd_valid[p]),
      .o_data    (ld_fwd_data[p])
    );
  end
`else
  logic w_unused_ld;
  assign w_unused_ld  = ^ld_addr;
  assign ld_fwd_valid = '0;
  assign ld_fwd_data  = '0;
`endif

endmodule
